// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter; VGA reads win every cycle,
// camera writes wait in a small FIFO and drain into cycles the display leaves free.
module fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 4,
   parameter int WQ_DEPTH   = 8,
   parameter int STARVE_LIM = 800
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_flush,
   input  logic              cam_wr_valid,
   output logic              cam_wr_ready,
   input  logic [ADDR_W-1:0] cam_wr_addr,
   input  logic [DATA_W-1:0] cam_wr_data,
   input  logic              vga_rd_req,
   input  logic [ADDR_W-1:0] vga_rd_addr,
   output logic              vga_rd_valid,
   output logic [DATA_W-1:0] vga_rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       drop_cnt,
   output logic              starve
);
   localparam int PW = $clog2(WQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE} grant_t;

   grant_t            grant;
   logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
   logic [DATA_W-1:0] q_data [WQ_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [SW-1:0]     starve_cnt;
   logic              rd_pend, empty, push, pop;

   // ready comes from registered occupancy only, so a same-cycle pop never frees a full slot
   assign empty        = count == '0;
   assign cam_wr_ready = count != CW'(WQ_DEPTH);
   assign push         = cam_wr_valid && cam_wr_ready && !frame_flush;
   assign pop          = grant == WRITE;
   assign starve       = starve_cnt >= SW'(STARVE_LIM);
   assign vga_rd_valid = rd_pend;
   assign vga_rd_data  = rd_pend ? mem_rdata : '0;

   always_comb begin
      grant     = vga_rd_req ? READ : (!empty && !frame_flush) ? WRITE : IDLE;
      mem_en    = grant != IDLE;
      mem_we    = grant == WRITE;
      mem_addr  = grant == READ ? vga_rd_addr : grant == WRITE ? q_addr[rd_ptr] : '0;
      mem_wdata = grant == WRITE ? q_data[rd_ptr] : '0;
   end

   always_ff @(posedge clk)
      if (push) begin
         q_addr[wr_ptr] <= cam_wr_addr;
         q_data[wr_ptr] <= cam_wr_data;
      end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         rd_pend    <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         rd_pend <= grant == READ;
         if (cam_wr_valid && !cam_wr_ready && drop_cnt != '1)
            drop_cnt <= drop_cnt + 16'd1;
         if (frame_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
         end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= (empty || pop) ? '0 : (vga_rd_req && !starve) ? starve_cnt + SW'(1) : starve_cnt;
         end
      end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- ADDR_W, 19, frame-buffer address width (640x480 pixel index).
- DATA_W, 4, pixel data width.
- WQ_DEPTH, 8, camera write-queue depth in entries (power of 2).
- STARVE_LIM, 800, consecutive denied-write cycles before starve flag.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock for all logic.
- reset_n, in, 1, asynchronous active-low reset.
- frame_flush, in, 1, synchronous pulse that empties the write queue.
- cam_wr_valid, in, 1, camera write request.
- cam_wr_ready, out, 1, queue can accept a write this cycle.
- cam_wr_addr, in, ADDR_W, camera pixel index.
- cam_wr_data, in, DATA_W, camera pixel value.
- vga_rd_req, in, 1, display read request (never stalled).
- vga_rd_addr, in, ADDR_W, display pixel index.
- vga_rd_valid, out, 1, read data valid.
- vga_rd_data, out, DATA_W, read data.
- mem_en, out, 1, single-port memory enable.
- mem_we, out, 1, single-port memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data (1-cycle latency after mem_en & !mem_we).
- drop_cnt, out, 16, count of camera writes offered while not ready.
- starve, out, 1, write starvation flag.

Function
REQ-003 Camera writes SHALL enter a FIFO of WQ_DEPTH {addr,data} entries; a push occurs when cam_wr_valid & cam_wr_ready.
REQ-004 cam_wr_ready SHALL equal !full, from registered occupancy only; a pop in the same cycle SHALL NOT enable a push when full.
REQ-005 The memory port SHALL be driven combinationally from the grant each cycle; grant states: IDLE, READ, WRITE.
REQ-006 READ SHALL be granted whenever vga_rd_req=1 (strict priority): mem_en=1, mem_we=0, mem_addr=vga_rd_addr.
REQ-007 WRITE SHALL be granted when vga_rd_req=0 and the FIFO is non-empty: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head; the head SHALL pop that cycle.
REQ-008 IDLE otherwise: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-009 vga_rd_valid SHALL be asserted exactly one cycle after each READ grant, with vga_rd_data=mem_rdata in that cycle; vga_rd_data SHALL be 0 when vga_rd_valid=0.
REQ-010 FIFO writes SHALL reach memory in push order; no entry SHALL be duplicated or lost except by frame_flush.
REQ-011 Simultaneous push and pop with FIFO neither empty nor full SHALL leave occupancy unchanged; push into an empty FIFO SHALL NOT be popped until the next cycle (1-cycle minimum queue latency).
REQ-012 Read/write pointers SHALL wrap modulo WQ_DEPTH; occupancy SHALL range 0..WQ_DEPTH.
REQ-013 drop_cnt SHALL increment by 1 each cycle with cam_wr_valid=1 and cam_wr_ready=0, saturating at 16'hFFFF.
REQ-014 A starve counter SHALL increment each cycle the FIFO is non-empty and vga_rd_req=1, reset to 0 on any WRITE grant or empty FIFO; starve SHALL be 1 while counter >= STARVE_LIM.
REQ-015 frame_flush SHALL, on the next edge, set occupancy to 0, pointers to 0 and the starve counter to 0; a push or pop in the flush cycle SHALL be discarded, and no WRITE SHALL be granted in the flush cycle; drop_cnt SHALL be unaffected.
REQ-016 frame_flush SHALL NOT affect a pending READ; vga_rd_valid SHALL still follow REQ-009.

Reset
REQ-017 While reset_n=0: FIFO empty, pointers 0, cam_wr_ready=1, vga_rd_valid=0, vga_rd_data=0, drop_cnt=0, starve=0, starve counter 0; mem_* SHALL follow REQ-006..008 from current inputs with the empty FIFO.
REQ-018 Reset assertion mid-operation SHALL discard all queued writes and any in-flight read valid immediately (asynchronously).
REQ-019 Reset deassertion SHALL be synchronized by the integrator; the block SHALL accept requests on the first edge after release.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Idle VGA, push 3 writes (addr 10/11/12, data 1/2/3) -> three WRITE grants in order on cycles 1..3 after first push, mem_we=1, FIFO empty after.
- vga_rd_req held 1 with 10 pushes at WQ_DEPTH=8 -> cam_wr_ready=0 after 8 pushes, drop_cnt=2, no mem_we while req=1.
- Alternate vga_rd_req 1/0 with queue full -> each req=0 cycle pops one entry; vga_rd_valid one cycle after every req with data from addr model.
- STARVE_LIM=4, FIFO non-empty, vga_rd_req=1 for 6 cycles -> starve rises after 4th cycle, clears after first WRITE grant.
- frame_flush with 5 queued entries and simultaneous push -> occupancy 0 next cycle, pushed entry absent, no WRITE in flush cycle.
- reset_n pulsed low with 4 queued and a read in flight -> vga_rd_valid=0, cam_wr_ready=1, drop_cnt=0 immediately.
